// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multi-cycle RV32I core: sequences the shared ALU and gates writes.
// Optional retired-instruction counter output enabled by defining INSTRET_CNT_EN.
module multicycle_main_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic             reg_write,
`ifdef INSTRET_CNT_EN
  output logic [CNT_W-1:0] instret,
`endif
  output logic             illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t state, state_next;
  logic   pc_update;
  logic   branch;
  logic   unused_funct3;

  assign unused_funct3 = ^funct3[2:1];

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        state_next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BR:        state_next = BRANCH;
          OP_JAL:       state_next = JAL;
          default: begin
            state_next = FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        state_next = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        state_next = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = FETCH;
    endcase
  end

  assign pc_write = pc_update | (branch & (zero ^ funct3[0]));

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

`ifdef INSTRET_CNT_EN
  logic retire;

  assign retire = (state == MEMWB) || (state == ALUWB) || (state == BRANCH) ||
                  ((state == MEMWRITE) && mem_ready);

  always_ff @(posedge clk) begin
    if (reset)       instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed self-checking bench for multicycle_main_fsm; exercises instret when INSTRET_CNT_EN is set.
module tb_multicycle_main_fsm;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
`ifdef INSTRET_CNT_EN
  logic [3:0] instret;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] ADD = 7'b0110011;
  localparam logic [6:0] ADI = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // Bundle order: pc_write adr_src mem_write ir_write result_src alu_src_a alu_src_b alu_op reg_write illegal
  localparam logic [13:0] E_FETCH_GO = 14'b1_0_0_1_10_00_10_00_0_0;
  localparam logic [13:0] E_FETCH_WT = 14'b0_0_0_0_10_00_10_00_0_0;
  localparam logic [13:0] E_DEC      = 14'b0_0_0_0_00_01_01_00_0_0;
  localparam logic [13:0] E_DEC_ILL  = 14'b0_0_0_0_00_01_01_00_0_1;
  localparam logic [13:0] E_MEMADR   = 14'b0_0_0_0_00_10_01_00_0_0;
  localparam logic [13:0] E_MEMREAD  = 14'b0_1_0_0_00_00_00_00_0_0;
  localparam logic [13:0] E_MEMWB    = 14'b0_0_0_0_01_00_00_00_1_0;
  localparam logic [13:0] E_MEMWR    = 14'b0_1_1_0_00_00_00_00_0_0;
  localparam logic [13:0] E_EXECR    = 14'b0_0_0_0_00_10_00_10_0_0;
  localparam logic [13:0] E_EXECI    = 14'b0_0_0_0_00_10_01_10_0_0;
  localparam logic [13:0] E_ALUWB    = 14'b0_0_0_0_00_00_00_00_1_0;
  localparam logic [13:0] E_BR_TAKE  = 14'b1_0_0_0_00_10_00_01_0_0;
  localparam logic [13:0] E_BR_NOT   = 14'b0_0_0_0_00_10_00_01_0_0;
  localparam logic [13:0] E_JAL      = 14'b1_0_0_0_00_01_10_00_0_0;

  always #5 clk = ~clk;

  multicycle_main_fsm #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .reg_write(reg_write),
`ifdef INSTRET_CNT_EN
    .instret(instret),
`endif
    .illegal(illegal));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [6:0] o, input logic [2:0] f3,
                     input logic z, input logic mr, input logic [13:0] exp);
    op = o; funct3 = f3; zero = z; mem_ready = mr;
    #1;
    chk(tag, {18'b0, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
              alu_src_b, alu_op, reg_write, illegal}, {18'b0, exp});
    @(posedge clk); #1;
  endtask

  task automatic cnt(input string tag, input logic [3:0] exp);
`ifdef INSTRET_CNT_EN
    chk(tag, {28'b0, instret}, {28'b0, exp});
`else
    if (exp === 4'hx) $display("unreachable %s", tag);
`endif
  endtask

  task automatic do_add(input string tag);
    cyc({tag, "_fetch"}, ADD, 3'b000, 1'b0, 1'b1, E_FETCH_GO);
    cyc({tag, "_dec"},   ADD, 3'b000, 1'b0, 1'b1, E_DEC);
    cyc({tag, "_execr"}, ADD, 3'b000, 1'b0, 1'b1, E_EXECR);
    cyc({tag, "_aluwb"}, ADD, 3'b000, 1'b0, 1'b1, E_ALUWB);
  endtask

  task automatic do_branch(input string tag, input logic [2:0] f3, input logic z,
                           input logic [13:0] e_br);
    cyc({tag, "_fetch"}, BR, f3, z, 1'b1, E_FETCH_GO);
    chk({tag, "_imm"}, {30'b0, imm_src}, 32'd2);
    cyc({tag, "_dec"},   BR, f3, z, 1'b1, E_DEC);
    cyc({tag, "_br"},    BR, f3, z, 1'b1, e_br);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; op = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    cnt("rst_instret", 4'd0);
    cyc("rst_fetch", 7'b0, 3'b000, 1'b0, 1'b0, E_FETCH_WT);

    do_add("add");
    chk("add_imm", {30'b0, imm_src}, 32'd0);
    cnt("cnt_add", 4'd1);

    // lw with two wait cycles in MEMREAD; MEMWB lands on cycle 7
    cyc("lw_fetch", LW, 3'b010, 1'b0, 1'b1, E_FETCH_GO);
    cyc("lw_dec",   LW, 3'b010, 1'b0, 1'b1, E_DEC);
    cyc("lw_adr",   LW, 3'b010, 1'b0, 1'b1, E_MEMADR);
    cyc("lw_rd_w1", LW, 3'b010, 1'b0, 1'b0, E_MEMREAD);
    cyc("lw_rd_w2", LW, 3'b010, 1'b0, 1'b0, E_MEMREAD);
    cyc("lw_rd_go", LW, 3'b010, 1'b0, 1'b1, E_MEMREAD);
    cyc("lw_wb",    LW, 3'b010, 1'b0, 1'b1, E_MEMWB);
    cnt("cnt_lw", 4'd2);

    do_branch("bne_z0", 3'b001, 1'b0, E_BR_TAKE);
    do_branch("bne_z1", 3'b001, 1'b1, E_BR_NOT);
    do_branch("beq_z1", 3'b000, 1'b1, E_BR_TAKE);
    cnt("cnt_br", 4'd5);

    cyc("addi_fetch", ADI, 3'b000, 1'b0, 1'b1, E_FETCH_GO);
    cyc("addi_dec",   ADI, 3'b000, 1'b0, 1'b1, E_DEC);
    cyc("addi_execi", ADI, 3'b000, 1'b0, 1'b1, E_EXECI);
    cyc("addi_aluwb", ADI, 3'b000, 1'b0, 1'b1, E_ALUWB);

    // sw with a fetch stall and one write wait cycle
    cyc("sw_fetch_wt", SW, 3'b010, 1'b0, 1'b0, E_FETCH_WT);
    cyc("sw_fetch",    SW, 3'b010, 1'b0, 1'b1, E_FETCH_GO);
    chk("sw_imm", {30'b0, imm_src}, 32'd1);
    cyc("sw_dec",      SW, 3'b010, 1'b0, 1'b1, E_DEC);
    cyc("sw_adr",      SW, 3'b010, 1'b0, 1'b1, E_MEMADR);
    cyc("sw_wr_wait",  SW, 3'b010, 1'b0, 1'b0, E_MEMWR);
    cyc("sw_wr_go",    SW, 3'b010, 1'b0, 1'b1, E_MEMWR);
    cnt("cnt_sw", 4'd7);

    cyc("ill_fetch", BAD, 3'b000, 1'b0, 1'b1, E_FETCH_GO);
    cyc("ill_dec",   BAD, 3'b000, 1'b0, 1'b1, E_DEC_ILL);
    cyc("ill_back",  BAD, 3'b000, 1'b0, 1'b0, E_FETCH_WT);
    cnt("cnt_ill", 4'd7);

    cyc("jal_fetch", JL, 3'b000, 1'b0, 1'b1, E_FETCH_GO);
    chk("jal_imm", {30'b0, imm_src}, 32'd3);
    cyc("jal_dec",   JL, 3'b000, 1'b0, 1'b1, E_DEC);
    cyc("jal_jal",   JL, 3'b000, 1'b0, 1'b1, E_JAL);
    cyc("jal_aluwb", JL, 3'b000, 1'b0, 1'b1, E_ALUWB);
    cnt("cnt_jal", 4'd8);

    // reset while a store is still waiting on memory
    cyc("swr_fetch", SW, 3'b010, 1'b0, 1'b1, E_FETCH_GO);
    cyc("swr_dec",   SW, 3'b010, 1'b0, 1'b1, E_DEC);
    cyc("swr_adr",   SW, 3'b010, 1'b0, 1'b1, E_MEMADR);
    cyc("swr_wr",    SW, 3'b010, 1'b0, 1'b0, E_MEMWR);
    reset = 1'b1;
    cyc("swr_wr_rst", SW, 3'b010, 1'b0, 1'b0, E_MEMWR);
    reset = 1'b0;
    cnt("cnt_swr", 4'd0);
    cyc("swr_fetch_after", SW, 3'b010, 1'b0, 1'b0, E_FETCH_WT);

    for (int i = 0; i < 17; i++) do_add($sformatf("wrap%0d", i));
    cnt("cnt_wrap", 4'd1);
    cyc("final_fetch", ADD, 3'b000, 1'b0, 1'b0, E_FETCH_WT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
